// File: rtl/vreg_pkg.sv
// Shared types and sizing for the vector register element streamer.
package vreg_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REG    = 16;
  localparam int NUM_ELE    = 32;
  // One extra bit so a count of NUM_ELE does not wrap to zero
  localparam int CNT_W      = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
  } beat_t;
endpackage

// File: rtl/vreg_out_stage.sv
// Single-entry valid/ready output register; a load wins over a consume in the same cycle.
module vreg_out_stage
  import vreg_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  beat_t beat_i,
  input  logic  ready_i,
  output logic  valid_o,
  output beat_t beat_o
);
  logic  vld_q;
  beat_t beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      beat_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      beat_q <= beat_i;
    end else if (vld_q && ready_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign valid_o = vld_q;
  assign beat_o  = beat_q;
endmodule

// File: rtl/vreg_elem_streamer.sv
// Walks one vector register through the RF read port and emits its elements as a
// valid/ready stream, one element per cycle when the consumer keeps up.
module vreg_elem_streamer
  import vreg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_reg,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] rf_rAddr1,
  output logic [ADDR_WIDTH-1:0] rf_rAddr2,
  input  logic [DATA_WIDTH-1:0] rf_rData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] reg_q, raddr2_q;
  logic [CNT_W-1:0]      len_q, cnt_q, eff_len;
  logic                  done_q, err_q;
  logic                  accept, cmd_bad, is_last, fire_rd, flush_hs;
  beat_t                 beat_in, beat_out;

  assign eff_len = (cmd_len > CNT_W'(NUM_ELE)) ? CNT_W'(NUM_ELE) : cmd_len;
  assign cmd_bad = int'(cmd_reg) >= NUM_REG;
  assign accept  = cmd_valid && cmd_ready;
  assign is_last = (cnt_q == len_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !cmd_bad && eff_len != '0) state_d = STREAM;
      STREAM:  if (fire_rd && is_last)                  state_d = FLUSH;
      FLUSH:   if (flush_hs)                            state_d = IDLE;
      default:                                          state_d = IDLE;
    endcase
  end

  // cmd_ready is gated by reset so nothing is offered while reset is held
  always_comb begin
    cmd_ready = (state_q == IDLE) && reset;
    busy      = (state_q != IDLE);
    fire_rd   = (state_q == STREAM) && (!out_valid || out_ready);
    flush_hs  = (state_q == FLUSH) && out_valid && out_ready;
    done      = done_q || flush_hs;
    err       = err_q;
  end

  // Read addresses only move while streaming, so they hold their last values in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_q    <= '0;
      raddr2_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        len_q <= eff_len;
        if (cmd_bad) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else if (eff_len == '0) begin
          done_q <= 1'b1;
        end else begin
          reg_q    <= cmd_reg;
          cnt_q    <= '0;
          raddr2_q <= '0;
        end
      end else if (fire_rd) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!is_last) raddr2_q <= raddr2_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign rf_rAddr1 = reg_q;
  assign rf_rAddr2 = raddr2_q;

  assign beat_in = '{data: rf_rData, idx: cnt_q[ADDR_WIDTH-1:0], last: is_last};

  vreg_out_stage u_out (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (fire_rd),
    .beat_i  (beat_in),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .beat_o  (beat_out)
  );

  assign out_data = beat_out.data;
  assign out_idx  = beat_out.idx;
  assign out_last = beat_out.last;
endmodule

// File: tb/tb_vreg_elem_streamer.sv
// Bench for vreg_elem_streamer: command table plus scoreboard of expected beats.
module tb_vreg_elem_streamer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_reg = '0;
  logic [5:0]  cmd_len = '0;
  logic [4:0]  rf_rAddr1, rf_rAddr2;
  logic [31:0] rf_rData;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy, done, err;

  vreg_elem_streamer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len), .rf_rAddr1(rf_rAddr1), .rf_rAddr2(rf_rAddr2),
    .rf_rData(rf_rData), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [0:31][0:31];
  assign rf_rData = rf[rf_rAddr1][rf_rAddr2];

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    int          r;
    int          len;
    int          mode;    // 0 ready high, 1 pattern 1,0,0, 2 random
    int          wr_idx;  // element overwritten mid-stream, -1 for none
    logic [31:0] wr_val;
    int          beats;
    int          err;
  } vec_t;
  vec_t tbl[8];

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int rmode = 0, phase = 0;
  int beats, vcyc, dones, errs, rdy_err;
  int acc_cyc, fv_cyc, first_cyc, last_cyc, done_cyc, err_cyc;
  bit   stall_q = 1'b0;
  exp_t hold;

  task automatic chk(input string nm, input longint got, input longint expv);
    nvec++;
    if (got != expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (rmode)
      1:       begin out_ready = (phase % 3 == 0); phase++; end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor samples late in the low phase, after the negedge drives have settled
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (reset) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (out_valid) begin
        vcyc++;
        if (fv_cyc < 0) fv_cyc = cyc;
      end
      if (done) begin dones++; done_cyc = cyc; end
      if (err)  begin errs++;  err_cyc = cyc; rdy_err = int'(cmd_ready); end
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold.data);
        chk("hold_idx", out_idx, hold.idx);
        chk("hold_last", out_last, hold.last);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_beat: got idx %0d data 0x%0h, want no beat", out_idx, out_data);
        end else begin
          e = expq.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_idx", out_idx, e.idx);
          chk("beat_last", out_last, e.last);
          chk("done_with_last", done, e.last);
        end
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      stall_q = out_valid && !out_ready;
      hold    = '{data: out_data, idx: out_idx, last: out_last};
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic clear_stats();
    beats = 0; vcyc = 0; dones = 0; errs = 0; rdy_err = -1;
    acc_cyc = -1; fv_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1; err_cyc = -1;
  endtask

  task automatic run_cmd(input vec_t v);
    int n, t0;
    n = (v.r < 16) ? ((v.len > 32) ? 32 : v.len) : 0;
    @(negedge clk);
    clear_stats();
    rmode = v.mode; phase = 0;
    for (int k = 0; k < n; k++)
      expq.push_back('{data: (k == v.wr_idx) ? v.wr_val : rf[v.r][k], idx: 5'(k), last: (k == n - 1)});
    cmd_valid = 1'b1; cmd_reg = 5'(v.r); cmd_len = 6'(v.len);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accepted", acc_cyc >= 0, 1);
    if (v.wr_idx >= 0) begin
      // land the write two cycles before the element is captured
      while (cyc < acc_cyc + v.wr_idx - 1) @(negedge clk);
      rf[v.r][v.wr_idx] = v.wr_val;
    end
    t0 = cyc;
    while (dones == 0 && cyc < t0 + 300) @(negedge clk);
    chk("done_seen", dones > 0, 1);
    repeat (2) @(negedge clk);
    chk("beat_count", beats, v.beats);
    chk("err_count", errs, v.err);
    chk("done_count", dones, 1);
    chk("sb_empty", expq.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cmd_ready, 1);
    if (v.beats > 0) begin
      chk("first_latency", fv_cyc - acc_cyc, 2);
      chk("done_at_last", done_cyc, last_cyc);
      if (v.mode == 0) chk("burst_len", last_cyc - first_cyc, v.beats - 1);
    end else begin
      chk("no_valid", vcyc, 0);
      chk("done_latency", done_cyc - acc_cyc, 1);
      if (v.err != 0) begin
        chk("err_latency", err_cyc - acc_cyc, 1);
        chk("err_ready", rdy_err, 1);
      end
    end
    expq.delete();
  endtask

  initial begin
    int t0;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 32; k++) rf[r][k] = 32'((r << 8) + k);

    tbl[0] = '{r: 3,  len: 32, mode: 0, wr_idx: -1, wr_val: 32'h0,    beats: 32, err: 0};
    tbl[1] = '{r: 5,  len: 4,  mode: 1, wr_idx: -1, wr_val: 32'h0,    beats: 4,  err: 0};
    tbl[2] = '{r: 1,  len: 0,  mode: 0, wr_idx: -1, wr_val: 32'h0,    beats: 0,  err: 0};
    tbl[3] = '{r: 1,  len: 40, mode: 0, wr_idx: -1, wr_val: 32'h0,    beats: 32, err: 0};
    tbl[4] = '{r: 16, len: 4,  mode: 0, wr_idx: -1, wr_val: 32'h0,    beats: 0,  err: 1};
    tbl[5] = '{r: 4,  len: 32, mode: 0, wr_idx: 7,  wr_val: 32'hDEAD, beats: 32, err: 0};
    tbl[6] = '{r: 15, len: 31, mode: 2, wr_idx: -1, wr_val: 32'h0,    beats: 31, err: 0};
    tbl[7] = '{r: 31, len: 1,  mode: 0, wr_idx: -1, wr_val: 32'h0,    beats: 0,  err: 1};
    clear_stats();

    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_addr1", rf_rAddr1, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

    // reset in the middle of a stream
    @(negedge clk);
    clear_stats();
    rmode = 0;
    for (int k = 0; k < 32; k++) expq.push_back('{data: rf[2][k], idx: 5'(k), last: (k == 31)});
    cmd_valid = 1'b1; cmd_reg = 5'd2; cmd_len = 6'd32;
    @(negedge clk);
    cmd_valid = 1'b0;
    t0 = cyc;
    while (beats < 10 && cyc < t0 + 100) @(negedge clk);
    chk("mid_beats", beats, 10);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr2", rf_rAddr2, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    expq.delete();
    run_cmd('{r: 2, len: 32, mode: 0, wr_idx: -1, wr_val: 32'h0, beats: 32, err: 0});
    chk("rst_cmd_no_done", dones, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vreg_elem_streamer.md
Name: vreg_elem_streamer

Overview:
- Read-side client of the vector register file. Walks one vector register element by element through one asynchronous read port (register address plus element address, combinational data return).
- Emits the elements as a valid/ready stream, one element per cycle at full throughput.
- Sits between the vector register file and store/reduction consumers. Commands arrive on a valid/ready command channel.

Parameters:
- ADDR_WIDTH, 5, width of register and element addresses
- DATA_WIDTH, 32, element width
- NUM_REG, 16, number of vector registers
- NUM_ELE, 32, elements per vector register

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_reg  in  ADDR_WIDTH  vector register to stream
- cmd_len  in  ADDR_WIDTH+1  element count (0..63)
- rf_rAddr1  out  ADDR_WIDTH  register file read-port register address
- rf_rAddr2  out  ADDR_WIDTH  register file read-port element address
- rf_rData  in  DATA_WIDTH  register file read data (combinational)
- out_valid  out  1  stream beat present
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_WIDTH  element value
- out_idx  out  ADDR_WIDTH  element index of beat
- out_last  out  1  final beat of command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse, rejected command (cmd_reg >= NUM_REG)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except cmd_ready, which is 1 once reset releases. Counters, address registers and the output register are cleared. Reset mid-stream abandons the command; no done pulse.
- States: IDLE, STREAM, FLUSH.
- cmd_ready = (state==IDLE).
- Command acceptance in IDLE:
  - Latch reg and eff_len = min(cmd_len, NUM_ELE).
  - If cmd_reg >= NUM_REG: pulse err and done next cycle, no beats, stay IDLE.
  - Else if eff_len==0: pulse done next cycle, no beats, stay IDLE.
  - Else: element counter = 0, go to STREAM.
- Read-port drive:
  - rf_rAddr1 = latched reg and rf_rAddr2 = element counter, both registered outputs.
  - Both hold their last values in IDLE.
- STREAM:
  - fire_rd = output register empty OR (out_valid && out_ready).
  - On fire_rd: capture rf_rData, counter, and (counter==eff_len-1) into out_data, out_idx and out_last; set out_valid; increment counter.
  - When the last element is captured, go to FLUSH.
  - Without fire_rd, the counter and addresses hold.
- FLUSH: wait for the handshake on the out_last beat. Then out_valid=0, pulse done in the same cycle as the last handshake, and go to IDLE.
- busy = (state != IDLE).
- Latency: command accepted in cycle T → first out_valid in cycle T+2. With out_ready held high, a burst of N elements completes in N consecutive cycles.
- Handshake rules:
  - out_data, out_idx and out_last stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
- Data consistency: each element is sampled in the cycle it is captured. A concurrent register file write to that element in the same cycle is not visible; a write landing before capture is visible. The streamer takes no snapshot.
- No back-to-back overlap: a new command is accepted no earlier than the cycle after done.
- Counter width ADDR_WIDTH+1 so NUM_ELE=32 does not wrap.

Decomposition:
- Shared package vreg_pkg holds ADDR_WIDTH, DATA_WIDTH, NUM_REG, NUM_ELE, the state enum typedef (IDLE/STREAM/FLUSH), and an element beat struct (data, idx, last).
- One natural sub-module: vreg_out_stage, a single-entry valid/ready output register with load/consume logic.
- The FSM and counter stay in the top module.

Test Plan:
- Preload reg 3 element k = 0x300+k. Send cmd_reg=3, cmd_len=32, out_ready=1. Expect 32 beats in consecutive cycles starting T+2, data 0x300..0x31F, idx 0..31, out_last only on idx 31, done in the same cycle as that beat.
- cmd_reg=5, cmd_len=4, out_ready toggling 1,0,0,1,... Expect beats idx 0..3, each held stable through stall cycles, exactly 4 handshakes, done with the idx 3 handshake.
- cmd_len=0, then cmd_len=40 on reg 1. Expect no beats plus a done pulse for the first; exactly 32 beats for the second (clamp).
- cmd_reg=16. Expect err and done pulses one cycle after acceptance, no out_valid, cmd_ready stays 1.
- Mid-stream on reg 2 after 10 beats, drive reset=0 for one cycle (asynchronous, between edges). Expect out_valid, busy and done to go 0 immediately. A following command on reg 2 restarts at idx 0.
- Register file write to reg 4 element 7 (value 0xDEAD) two cycles before the streamer captures idx 7. Expect out_data=0xDEAD at idx 7.
